// File: rtl/seg_link_pkg.sv
// seg_link_pkg: shared state encoding and seven-segment patterns for the serial display link.
// The pattern table is also used by the transmitter-side encoder.
package seg_link_pkg;
    typedef logic [1:0] state_t;
    localparam state_t WAIT_GAP = 2'd0;
    localparam state_t IDLE     = 2'd1;
    localparam state_t SHIFT    = 2'd2;
    localparam state_t DONE     = 2'd3;
    localparam int FRAME_BITS = 8;
    // Index i holds the {g..a} pattern for hex digit i.
    localparam logic [15:0][6:0] SEG_PAT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: maps a 7-bit {g..a} segment pattern back to its hex value.
// valid is low for any pattern outside the 16-entry table.
module seg7_decode
    import seg_link_pkg::*;
(
    input  logic [6:0] pat,
    output logic       valid,
    output logic [3:0] hex
);
    always_comb begin
        valid = 1'b0;
        hex   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pat == SEG_PAT[i]) begin
                valid = 1'b1;
                hex   = 4'(i);
            end
        end
    end
endmodule

// File: rtl/seg_frame_receiver.sv
// seg_frame_receiver: samples serial segment lanes on shift_in edges, assembles
// 8-bit frames per digit and decodes them to hex, flagging bad patterns and truncated frames.
module seg_frame_receiver
    import seg_link_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int IDLE_CYCLES = 64,
    parameter int IDLE_W      = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     seg_in,
    input  logic                  shift_in,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic                  frame_valid,
    output logic [DIGITS-1:0]     pattern_err,
    output logic                  frame_err
);
    logic [DIGITS-1:0]        seg_s1, seg_s2;
    logic                     sh_s1, sh_s2, sh_d;
    logic                     rise, gap, shift_en;
    logic [IDLE_W-1:0]        idle;
    logic [3:0]               bitcnt;
    state_t                   state;
    logic [DIGITS-1:0][7:0]   sr;
    logic [DIGITS-1:0]        dec_valid;
    logic [DIGITS-1:0][3:0]   dec_hex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            sh_s1  <= 1'b0;
            sh_s2  <= 1'b0;
            sh_d   <= 1'b0;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            sh_s1  <= shift_in;
            sh_s2  <= sh_s1;
            sh_d   <= sh_s2;
        end
    end

    assign rise     = sh_s2 & ~sh_d;
    assign gap      = (idle == IDLE_W'(IDLE_CYCLES));
    assign shift_en = rise && (state != WAIT_GAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle <= '0;
        else        idle <= rise ? '0 : (gap ? idle : idle + 1'b1);
    end

    for (genvar j = 0; j < DIGITS; j++) begin : g_lane
        seg7_decode u_dec (
            .pat   (sr[j][6:0]),
            .valid (dec_valid[j]),
            .hex   (dec_hex[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_GAP;
            bitcnt      <= '0;
            sr          <= '0;
            digits_out  <= '0;
            dp_out      <= '0;
            pattern_err <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (shift_en) begin
                for (int j = 0; j < DIGITS; j++) sr[j] <= {sr[j][6:0], seg_s2[j]};
            end
            case (state)
                WAIT_GAP: if (gap) state <= IDLE;
                IDLE: begin
                    if (rise) begin
                        bitcnt <= 4'd1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'(FRAME_BITS - 1)) state <= DONE;
                    end else if (gap) begin
                        frame_err <= 1'b1;
                        bitcnt    <= '0;
                        state     <= WAIT_GAP;
                    end
                end
                default: begin
                    // sr still holds the completed frame here; a rise this cycle starts the next one.
                    frame_valid <= 1'b1;
                    for (int j = 0; j < DIGITS; j++) begin
                        if (dec_valid[j]) begin
                            digits_out[4*j +: 4] <= dec_hex[j];
                            dp_out[j]            <= sr[j][7];
                            pattern_err[j]       <= 1'b0;
                        end else begin
                            pattern_err[j] <= 1'b1;
                        end
                    end
                    bitcnt <= rise ? 4'd1 : 4'd0;
                    state  <= rise ? SHIFT : IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seg_frame_receiver.sv
// tb_seg_frame_receiver: directed scenarios for the serial segment frame receiver.
module tb_seg_frame_receiver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] seg_in = 2'b00;
    logic       shift_in = 1'b0;
    logic [7:0] digits_out;
    logic [1:0] dp_out;
    logic       frame_valid;
    logic [1:0] pattern_err;
    logic       frame_err;

    int vectors = 0;
    int errors  = 0;
    int fv_cnt  = 0;
    int fe_cnt  = 0;
    int fv0, fe0;

    seg_frame_receiver #(.DIGITS(2), .IDLE_CYCLES(64), .IDLE_W(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .shift_in    (shift_in),
        .digits_out  (digits_out),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (frame_err)   fe_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends bits [from, to) of each lane byte MSB first, 4 clk low then 4 clk high.
    task automatic send_bits(input logic [7:0] l0, input logic [7:0] l1, input int from, input int to);
        for (int i = from; i < to; i++) begin
            shift_in = 1'b0;
            seg_in   = {l1[7-i], l0[7-i]};
            wait_clk(4);
            shift_in = 1'b1;
            wait_clk(4);
        end
        shift_in = 1'b0;
    endtask

    task automatic expect_frame(input string name, input int fv_exp, input logic [7:0] dig, input logic [1:0] dp, input logic [1:0] pe);
        vectors++;
        if (fv_cnt - fv0 !== fv_exp) begin
            errors++;
            $display("FAIL %s frame_valid pulses: got %0d expected %0d", name, fv_cnt - fv0, fv_exp);
        end
        vectors++;
        if (digits_out !== dig) begin
            errors++;
            $display("FAIL %s digits_out: got %h expected %h", name, digits_out, dig);
        end
        vectors++;
        if (dp_out !== dp) begin
            errors++;
            $display("FAIL %s dp_out: got %b expected %b", name, dp_out, dp);
        end
        vectors++;
        if (pattern_err !== pe) begin
            errors++;
            $display("FAIL %s pattern_err: got %b expected %b", name, pattern_err, pe);
        end
    endtask

    task automatic full_frame(input logic [7:0] l0, input logic [7:0] l1);
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        send_bits(l0, l1, 0, 8);
        wait_clk(10);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_clk(3);
        vectors++;
        if ({digits_out, dp_out, pattern_err, frame_valid, frame_err} !== 14'd0) begin
            errors++;
            $display("FAIL reset outputs: got %h expected 0", {digits_out, dp_out, pattern_err, frame_valid, frame_err});
        end
        rst_n = 1'b1;
        wait_clk(66);
    endtask

    task automatic test_basic;
        full_frame(8'h3F, 8'h06);
        expect_frame("basic", 1, 8'h10, 2'b00, 2'b00);
    endtask

    task automatic test_dp;
        full_frame(8'hFF, 8'h71);
        expect_frame("dp", 1, 8'hF8, 2'b01, 2'b00);
    endtask

    task automatic test_bad_pattern;
        full_frame(8'h5B, 8'h4F);
        expect_frame("good23", 1, 8'h32, 2'b00, 2'b00);
        full_frame(8'h6D, 8'h49);
        expect_frame("bad_lane1", 1, 8'h35, 2'b00, 2'b10);
    endtask

    task automatic test_truncated;
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        send_bits(8'h3F, 8'h3F, 0, 5);
        wait_clk(80);
        vectors++;
        if (fe_cnt - fe0 !== 1) begin
            errors++;
            $display("FAIL trunc frame_err pulses: got %0d expected 1", fe_cnt - fe0);
        end
        expect_frame("trunc", 0, 8'h35, 2'b00, 2'b10);
        full_frame(8'h7F, 8'h06);
        expect_frame("after_trunc", 1, 8'h18, 2'b00, 2'b00);
    endtask

    task automatic test_no_gap;
        rst_n = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        full_frame(8'h3F, 8'h3F);
        expect_frame("no_gap", 0, 8'h00, 2'b00, 2'b00);
        wait_clk(70);
        full_frame(8'h66, 8'h6D);
        expect_frame("after_gap", 1, 8'h54, 2'b00, 2'b00);
        full_frame(8'hE6, 8'h6D);
        expect_frame("dp_set", 1, 8'h54, 2'b01, 2'b00);
    endtask

    task automatic test_async_reset;
        fv0 = fv_cnt;
        send_bits(8'h06, 8'h06, 0, 4);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({digits_out, dp_out, pattern_err, frame_valid, frame_err} !== 14'd0) begin
            errors++;
            $display("FAIL async_reset outputs: got %h expected 0", {digits_out, dp_out, pattern_err, frame_valid, frame_err});
        end
        wait_clk(1);
        rst_n = 1'b1;
        send_bits(8'h06, 8'h06, 4, 8);
        wait_clk(10);
        vectors++;
        if (fv_cnt - fv0 !== 0) begin
            errors++;
            $display("FAIL async_reset frame_valid pulses: got %0d expected 0", fv_cnt - fv0);
        end
        wait_clk(70);
        full_frame(8'h5B, 8'h07);
        expect_frame("after_reset", 1, 8'h72, 2'b00, 2'b00);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_dp;
        test_bad_pattern;
        test_truncated;
        test_no_gap;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
